// File: rtl/matrix_dim_dump_engine.sv
// matrix_dim_dump_engine
//   Dumps stored matrices to the shared UART as ASCII. SINGLE mode prints every
//   matrix of one m x n shape; ALL mode walks every non-empty shape in raster
//   order. Each shape gets a header line, each matrix an index line, and the
//   matrix body itself is handed to matrix_printer.
//   Optional feature macro: MATRIX_DUMP_TIMEOUT_EN -- abort with err_code 3 when
//   storage stays silent for TMO_CYC cycles after a read strobe.
module matrix_dim_dump_engine #(
  parameter int MAX_DIM = 5,
  parameter int CNT_W   = 2,
  parameter int ELEM_W  = 8,
  parameter int DIM_W   = 3,
  parameter int IDX_W   = 2,
  parameter int TMO_CYC = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              mode,
  input  logic [DIM_W-1:0]                  dim_m,
  input  logic [DIM_W-1:0]                  dim_n,
  input  logic [MAX_DIM*MAX_DIM*CNT_W-1:0]  info_table,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic                              read_en,
  output logic [DIM_W-1:0]                  rd_m,
  output logic [DIM_W-1:0]                  rd_n,
  output logic [IDX_W-1:0]                  rd_idx,
  input  logic                              rd_ready,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] rd_data,
  output logic                              prt_start,
  input  logic                              prt_done,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] prt_data,
  input  logic                              uart_tx_busy,
  output logic                              uart_tx_en,
  output logic [7:0]                        uart_tx_data
);

  localparam int TBL_W  = MAX_DIM * MAX_DIM * CNT_W;
  localparam int DATA_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_SCAN, S_HDR, S_TX, S_IDXH, S_RD,
    S_RWAIT, S_PRT, S_PWAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  // One text line of at most 8 bytes, first byte in data[7:0].
  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  len;
  } line_t;

  // Count of the slot holding shape m x n; callers only pass legal shapes.
  function automatic logic [CNT_W-1:0] slot_cnt(input logic [TBL_W-1:0] tbl,
                                                input logic [DIM_W-1:0] m,
                                                input logic [DIM_W-1:0] n);
    int p;
    p = 0;
    if (m != '0 && n != '0 && m <= DIM_MAX && n <= DIM_MAX)
      p = (int'(m) - 1) * MAX_DIM + int'(n) - 1;
    return tbl[p*CNT_W +: CNT_W];
  endfunction

  // Formats "<num>\r\n" or "<m>*<n>*<num>\r\n" with leading zeros suppressed.
  function automatic line_t fmt_line(input logic with_shape,
                                     input logic [DIM_W-1:0] m,
                                     input logic [DIM_W-1:0] n,
                                     input logic [6:0] num);
    line_t l;
    int k;
    logic [6:0] tens;
    logic [6:0] ones;
    l.data = '0;
    k = 0;
    tens = num / 7'd10;
    ones = num % 7'd10;
    if (with_shape) begin
      l.data[k*8 +: 8] = 8'h30 + 8'(m); k++;
      l.data[k*8 +: 8] = 8'h2a;         k++;
      l.data[k*8 +: 8] = 8'h30 + 8'(n); k++;
      l.data[k*8 +: 8] = 8'h2a;         k++;
    end
    if (tens != '0) begin
      l.data[k*8 +: 8] = 8'h30 + {1'b0, tens}; k++;
    end
    l.data[k*8 +: 8] = 8'h30 + {1'b0, ones}; k++;
    l.data[k*8 +: 8] = 8'h0d; k++;
    l.data[k*8 +: 8] = 8'h0a; k++;
    l.len = 4'(k);
    return l;
  endfunction

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [TBL_W-1:0]   info_q, info_d;
  logic [DIM_W-1:0]   cur_m_q, cur_m_d, cur_n_q, cur_n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               found_q, found_d;
  logic               hdr_phase_q, hdr_phase_d;
  logic [63:0]        line_q, line_d;
  logic [3:0]         len_q, len_d, ptr_q, ptr_d;
  logic               inflight_q, inflight_d;
  logic               busy_s_q;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               read_en_q, read_en_d, prt_start_q, prt_start_d;
  logic [DATA_W-1:0]  prt_data_q, prt_data_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
`ifdef MATRIX_DUMP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

  logic [CNT_W-1:0]   cnt_cur;
  logic               dims_ok, last_slot;

  assign cnt_cur   = slot_cnt(info_q, cur_m_q, cur_n_q);
  assign dims_ok   = cur_m_q != '0 && cur_n_q != '0 && cur_m_q <= DIM_MAX && cur_n_q <= DIM_MAX;
  assign last_slot = cur_m_q == DIM_MAX && cur_n_q == DIM_MAX;

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    info_d      = info_q;
    cur_m_d     = cur_m_q;
    cur_n_d     = cur_n_q;
    idx_d       = idx_q;
    found_d     = found_q;
    hdr_phase_d = hdr_phase_q;
    line_d      = line_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    inflight_d  = inflight_q;
    busy_d      = busy_q;
    err_code_d  = err_code_q;
    prt_data_d  = prt_data_q;
    tx_data_d   = tx_data_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    read_en_d   = 1'b0;
    prt_start_d = 1'b0;
    tx_en_d     = 1'b0;
`ifdef MATRIX_DUMP_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        mode_d     = mode;
        info_d     = info_table;
        cur_m_d    = mode ? DIM_ONE : dim_m;
        cur_n_d    = mode ? DIM_ONE : dim_n;
        idx_d      = '0;
        found_d    = 1'b0;
        err_code_d = 2'd0;
        busy_d     = 1'b1;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (mode_q) state_d = S_SCAN;
        else if (!dims_ok) begin
          state_d = S_ERR; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd1;
        end else if (cnt_cur == '0) begin
          state_d = S_ERR; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd2;
        end else state_d = S_HDR;
      end
      S_SCAN: begin
        if (cnt_cur != '0) begin
          found_d = 1'b1;
          state_d = S_HDR;
        end else if (last_slot) begin
          state_d = found_q ? S_DONE : S_ERR;
          busy_d  = 1'b0;
          done_d  = found_q;
          error_d = !found_q;
          if (!found_q) err_code_d = 2'd2;
        end else if (cur_n_q == DIM_MAX) begin
          cur_n_d = DIM_ONE; cur_m_d = cur_m_q + DIM_ONE;
        end else cur_n_d = cur_n_q + DIM_ONE;
      end
      S_HDR: begin
        {line_d, len_d} = fmt_line(mode_q, cur_m_q, cur_n_q, 7'(cnt_cur));
        ptr_d = '0; hdr_phase_d = 1'b1; state_d = S_TX;
      end
      S_IDXH: begin
        {line_d, len_d} = fmt_line(1'b0, cur_m_q, cur_n_q, 7'(idx_q) + 7'd1);
        ptr_d = '0; hdr_phase_d = 1'b0; state_d = S_TX;
      end
      S_TX: begin
        // A byte completes on the registered falling edge of the UART busy flag.
        if (inflight_q) begin
          if (busy_s_q && !uart_tx_busy) inflight_d = 1'b0;
        end else if (ptr_q == len_q) begin
          state_d = hdr_phase_q ? S_IDXH : S_RD;
        end else if (!uart_tx_busy) begin
          tx_en_d    = 1'b1;
          tx_data_d  = line_q[int'(ptr_q)*8 +: 8];
          ptr_d      = ptr_q + 4'd1;
          inflight_d = 1'b1;
        end
      end
      S_RD: begin
        read_en_d = 1'b1;
        state_d   = S_RWAIT;
`ifdef MATRIX_DUMP_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      S_RWAIT: begin
        if (rd_ready) begin
          prt_data_d  = rd_data;
          prt_start_d = 1'b1;
          state_d     = S_PRT;
        end
`ifdef MATRIX_DUMP_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          state_d = S_ERR; busy_d = 1'b0; error_d = 1'b1; err_code_d = 2'd3;
        end else tmo_d = tmo_q + TMO_W'(1);
`else
        // Without the timeout the engine waits for storage indefinitely.
`endif
      end
      S_PRT:   state_d = S_PWAIT;
      S_PWAIT: if (prt_done) state_d = S_NEXT;
      S_NEXT: begin
        if (7'(idx_q) + 7'd1 < 7'(cnt_cur)) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_IDXH;
        end else begin
          idx_d = '0;
          if (!mode_q || last_slot) begin
            state_d = S_DONE; busy_d = 1'b0; done_d = 1'b1;
          end else begin
            state_d = S_SCAN;
            if (cur_n_q == DIM_MAX) begin
              cur_n_d = DIM_ONE; cur_m_d = cur_m_q + DIM_ONE;
            end else cur_n_d = cur_n_q + DIM_ONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts at once with no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      info_q      <= '0;
      cur_m_q     <= '0;
      cur_n_q     <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      hdr_phase_q <= 1'b0;
      line_q      <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      inflight_q  <= 1'b0;
      busy_s_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      read_en_q   <= 1'b0;
      prt_start_q <= 1'b0;
      prt_data_q  <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'd0;
`ifdef MATRIX_DUMP_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      info_q      <= info_d;
      cur_m_q     <= cur_m_d;
      cur_n_q     <= cur_n_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      hdr_phase_q <= hdr_phase_d;
      line_q      <= line_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      busy_s_q    <= uart_tx_busy;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      read_en_q   <= read_en_d;
      prt_start_q <= prt_start_d;
      prt_data_q  <= prt_data_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
`ifdef MATRIX_DUMP_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign read_en      = read_en_q;
  assign rd_m         = cur_m_q;
  assign rd_n         = cur_n_q;
  assign rd_idx       = idx_q;
  assign prt_start    = prt_start_q;
  assign prt_data     = prt_data_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;

endmodule

// File: tb/tb_matrix_dim_dump_engine.sv
// Directed bench for matrix_dim_dump_engine with small UART, storage and
// printer models. CR is shown as '^' and LF as '|' in captured UART text.
`timescale 1ns/1ps
module tb_matrix_dim_dump_engine;
  localparam int MAX_DIM = 5, CNT_W = 4, ELEM_W = 8, DIM_W = 3, IDX_W = 4, TMO = 64;
  localparam int TBL_W  = MAX_DIM * MAX_DIM * CNT_W;
  localparam int DATA_W = MAX_DIM * MAX_DIM * ELEM_W;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [DIM_W-1:0] dim_m = '0, dim_n = '0;
  logic [TBL_W-1:0] info_table = '0;
  logic busy, done, error, read_en, prt_start, uart_tx_en;
  logic [1:0] err_code;
  logic [DIM_W-1:0] rd_m, rd_n;
  logic [IDX_W-1:0] rd_idx;
  logic rd_ready = 1'b0, prt_done = 1'b0, uart_tx_busy = 1'b0;
  logic [DATA_W-1:0] rd_data = '0, prt_data;
  logic [7:0] uart_tx_data;

  matrix_dim_dump_engine #(.MAX_DIM(MAX_DIM), .CNT_W(CNT_W), .ELEM_W(ELEM_W),
                           .DIM_W(DIM_W), .IDX_W(IDX_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dim_m(dim_m), .dim_n(dim_n),
    .info_table(info_table), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .read_en(read_en), .rd_m(rd_m), .rd_n(rd_n),
    .rd_idx(rd_idx), .rd_ready(rd_ready), .rd_data(rd_data), .prt_start(prt_start),
    .prt_done(prt_done), .prt_data(prt_data), .uart_tx_busy(uart_tx_busy),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, tx_cnt = 0, read_cnt = 0, prt_cnt = 0, done_cnt = 0, err_cnt = 0;
  int en_viol = 0, pulse_viol = 0, read_cyc = 0, err_cyc = 0;
  int ub_cnt = 0, rd_wait = 0, pw_cnt = 0;
  bit mute = 1'b0;
  string rx_s = "", rd_log = "";
  logic [DATA_W-1:0] prt_last = '0;
  logic [DIM_W-1:0] sm, sn;
  logic [IDX_W-1:0] si;
  int b_tx, b_rd, b_prt, b_done, b_err, b_rx, b_log, n_wait;

  function automatic logic [DATA_W-1:0] mat_pat(input int m, input int n, input int idx);
    logic [DATA_W-1:0] p;
    p = {(MAX_DIM*MAX_DIM){8'hA5}};
    p[23:0] = p[23:0] ^ {8'(m), 8'(n), 8'(idx)};
    return p;
  endfunction

  function automatic string show(input logic [7:0] b);
    if (b == 8'h0d) return "^";
    if (b == 8'h0a) return "|";
    return $sformatf("%c", b);
  endfunction

  function automatic string tail(input string s, input int base);
    if (base >= s.len()) return "";
    return s.substr(base, s.len() - 1);
  endfunction

  function automatic logic [TBL_W-1:0] set_slot(input logic [TBL_W-1:0] t, input int m,
                                                input int n, input int c);
    logic [TBL_W-1:0] r;
    r = t;
    r[((m-1)*MAX_DIM + n - 1)*CNT_W +: CNT_W] = CNT_W'(c);
    return r;
  endfunction

  function automatic logic [255:0] all_outs();
    return 256'({busy, done, error, err_code, read_en, rd_m, rd_n, rd_idx,
                 prt_start, prt_data, uart_tx_en, uart_tx_data});
  endfunction

  // UART, storage and printer models plus pulse bookkeeping.
  always @(posedge clk) begin
    cyc++;
    rd_ready <= 1'b0;
    prt_done <= 1'b0;
    if (uart_tx_en) begin
      if (uart_tx_busy) en_viol++;
      rx_s = {rx_s, show(uart_tx_data)};
      tx_cnt++;
      ub_cnt = 3;
      uart_tx_busy <= 1'b1;
    end else if (ub_cnt > 0) begin
      ub_cnt--;
      if (ub_cnt == 0) uart_tx_busy <= 1'b0;
    end
    if (read_en) begin
      rd_log = {rd_log, $sformatf("%0d%0d:%0d ", rd_m, rd_n, rd_idx)};
      read_cnt++;
      read_cyc = cyc;
      if (!mute) begin rd_wait = 2; sm = rd_m; sn = rd_n; si = rd_idx; end
    end else if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        rd_ready <= 1'b1;
        rd_data  <= mat_pat(int'(sm), int'(sn), int'(si));
      end
    end
    if (prt_start) begin
      prt_cnt++;
      prt_last = prt_data;
      pw_cnt = 3;
    end else if (pw_cnt > 0) begin
      pw_cnt--;
      if (pw_cnt == 0) prt_done <= 1'b1;
    end
    if (done) done_cnt++;
    if (error) begin err_cnt++; err_cyc = cyc; end
    if ((done || error) && busy) pulse_viol++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: got \"%s\" want \"%s\"", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_tx = tx_cnt; b_rd = read_cnt; b_prt = prt_cnt; b_done = done_cnt;
    b_err = err_cnt; b_rx = rx_s.len(); b_log = rd_log.len();
  endtask

  task automatic run(input string tag, input logic md, input int m, input int n,
                     input logic [TBL_W-1:0] tbl);
    snap();
    mode = md; dim_m = DIM_W'(m); dim_n = DIM_W'(n); info_table = tbl; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, " busy_after_start"}, 256'(busy), 256'(1));
    start = 1'b0;
    info_table = '0;  // latched copy must be used for the whole run
    n_wait = 0;
    while (done_cnt == b_done && err_cnt == b_err && n_wait < 5000) begin
      @(posedge clk); #1;
      n_wait++;
    end
    chk({tag, " finished_in_budget"}, 256'(n_wait < 5000), 256'(1));
    repeat (4) @(posedge clk);
    #1;
  endtask

  string exp_s, exp_log;

  initial begin
    // Reset state, both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_during", all_outs(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_outs_after", all_outs(), '0);

    // 1. SINGLE 2x3, count 2.
    run("t1", 1'b0, 2, 3, set_slot('0, 2, 3, 2));
    chks("t1 uart", tail(rx_s, b_rx), "2^|1^|2^|");
    chks("t1 reads", tail(rd_log, b_log), "23:0 23:1 ");
    chk("t1 done_cnt", 256'(done_cnt - b_done), 256'(1));
    chk("t1 err_cnt", 256'(err_cnt - b_err), 256'(0));
    chk("t1 prt_cnt", 256'(prt_cnt - b_prt), 256'(2));
    chk("t1 prt_data", 256'(prt_last), 256'(mat_pat(2, 3, 1)));
    chk("t1 err_code", 256'(err_code), 256'(0));
    chk("t1 busy_idle", 256'(busy), 256'(0));

    // 2. SINGLE 4x4, count 0 -> empty.
    run("t2", 1'b0, 4, 4, set_slot('0, 2, 3, 2));
    chk("t2 err_cnt", 256'(err_cnt - b_err), 256'(1));
    chk("t2 err_code", 256'(err_code), 256'(2));
    chk("t2 reads", 256'(read_cnt - b_rd), 256'(0));
    chk("t2 tx", 256'(tx_cnt - b_tx), 256'(0));

    // 3. Bad dimensions.
    run("t3a", 1'b0, 6, 2, set_slot('0, 5, 2, 1));
    chk("t3a err_code", 256'(err_code), 256'(1));
    chk("t3a err_cnt", 256'(err_cnt - b_err), 256'(1));
    run("t3b", 1'b0, 3, 0, set_slot('0, 3, 1, 1));
    chk("t3b err_code", 256'(err_code), 256'(1));

    // 4. ALL mode, slots 1x1 and 5x5.
    run("t4", 1'b1, 0, 0, set_slot(set_slot('0, 1, 1, 1), 5, 5, 1));
    chks("t4 uart", tail(rx_s, b_rx), "1*1*1^|1^|5*5*1^|1^|");
    chks("t4 reads", tail(rd_log, b_log), "11:0 55:0 ");
    chk("t4 done_cnt", 256'(done_cnt - b_done), 256'(1));
    chk("t4 prt_data", 256'(prt_last), 256'(mat_pat(5, 5, 0)));
    chk("t4 err_code", 256'(err_code), 256'(0));

    // 5. Two-digit count 12.
    run("t5", 1'b0, 3, 2, set_slot('0, 3, 2, 12));
    exp_s = "12^|";
    exp_log = "";
    for (int i = 1; i <= 12; i++) begin
      exp_s = {exp_s, $sformatf("%0d^|", i)};
      exp_log = {exp_log, $sformatf("32:%0d ", i - 1)};
    end
    chks("t5 uart", tail(rx_s, b_rx), exp_s);
    chks("t5 reads", tail(rd_log, b_log), exp_log);
    chk("t5 done_cnt", 256'(done_cnt - b_done), 256'(1));
    chk("t5 prt_data", 256'(prt_last), 256'(mat_pat(3, 2, 11)));

    // ALL mode with nothing stored -> empty error.
    run("t_all_empty", 1'b1, 0, 0, '0);
    chk("t_all_empty err_code", 256'(err_code), 256'(2));
    chk("t_all_empty tx", 256'(tx_cnt - b_tx), 256'(0));

    // Reset in the middle of a header transmission.
    snap();
    mode = 1'b0; dim_m = 3'd2; dim_n = 3'd3; info_table = set_slot('0, 2, 3, 2); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_wait = 0;
    while (tx_cnt == b_tx && n_wait < 200) begin @(posedge clk); #1; n_wait++; end
    chk("rst_mid reached_tx", 256'(n_wait < 200), 256'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid outs", all_outs(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_mid no_pulse", 256'((done_cnt - b_done) + (err_cnt - b_err)), 256'(0));
    chk("rst_mid busy", 256'(busy), 256'(0));

    // Recovery after the aborted run.
    run("t_recover", 1'b0, 1, 1, set_slot('0, 1, 1, 1));
    chks("t_recover uart", tail(rx_s, b_rx), "1^|1^|");
    chk("t_recover done_cnt", 256'(done_cnt - b_done), 256'(1));

`ifdef MATRIX_DUMP_TIMEOUT_EN
    // 6. Storage never answers.
    mute = 1'b1;
    run("t6", 1'b0, 2, 3, set_slot('0, 2, 3, 2));
    chk("t6 err_code", 256'(err_code), 256'(3));
    chk("t6 prt_cnt", 256'(prt_cnt - b_prt), 256'(0));
    chk("t6 latency", 256'(err_cyc - read_cyc), 256'(TMO));
    mute = 1'b0;
`endif

    chk("strobe_while_busy", 256'(en_viol), 256'(0));
    chk("pulse_with_busy", 256'(pulse_viol), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
